mux_cdc_tx_arbiter: RTL and testbench
=====================================

# mux_cdc_tx_arbiter

Source-domain scheduler for a shared mux/N-flop CDC data channel. It round-robins between NREQ requesters and loads the winner's word onto the channel input. It holds that word stable long enough for the destination's stability-detect and pulse synchronizer to capture it, then enforces a gap before the next word. One toggle tag bit travels with the word so that back-to-back identical words still produce a detectable change.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..16)
- DW, 8, data width per requester
- HOLD_CYC, 6, cycles the word is held stable (>=1); must cover destination capture latency: HOLD_CYC·Tclk >= 4 destination clock periods
- GAP_CYC, 2, idle cycles after HOLD before re-arbitration (0 allowed)

Ports:
- clk  in  1  source-domain clock; single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request level; held until grant
- req_data  in  NREQ*DW  requester i word at bits [i*DW +: DW]
- gnt  out  NREQ  one-hot, one-cycle grant pulse
- tx_data  out  DW  word to channel input (registered)
- tx_tag  out  1  toggles on every new word; concatenate {tx_tag, tx_data} into the channel
- sel_id  out  clog2(NREQ)  index of last granted requester
- busy  out  1  high whenever state != IDLE
- ack  in  1  (MUX_ARB_ACK_EN only) single-cycle capture acknowledge, already synchronized into clk
- err  out  1  (MUX_ARB_ACK_EN only) sticky ack-timeout flag

## Operation
- States: IDLE, HOLD, GAP.
- IDLE: if any req bit is set, pick the winner by round-robin, searching upward from last_winner+1 with wrap. At the edge:
  - tx_data <= req_data[winner]
  - tx_tag <= ~tx_tag
  - gnt[winner] <= 1
  - sel_id <= winner
  - last_winner <= winner
  - cnt <= HOLD_CYC-1
  - state <= HOLD
- HOLD: cnt decrements each cycle. At cnt==0: go to GAP with cnt <= GAP_CYC-1, or go straight to IDLE when GAP_CYC==0.
- GAP: cnt decrements; at cnt==0, go to IDLE.
- tx_data and tx_tag change only on a grant edge. They stay stable through HOLD, GAP and IDLE.
- req is not sampled outside IDLE. A requester dropping req before its grant is simply skipped. req_data is sampled only at the grant edge.
- gnt is high for exactly one cycle: the first HOLD cycle.
- Reset values: state IDLE, gnt 0, tx_data 0, tx_tag 0, sel_id 0, busy 0, err 0, cnt 0. last_winner resets to NREQ-1, so requester 0 has first priority.
- Reset asserted mid-HOLD/GAP aborts immediately on the next edge. The aborted word is not retried. The requester already saw gnt.

## Timing
- req sampled high in IDLE cycle k -> gnt, tx_data, tx_tag and busy updated at cycle k+1.
- HOLD spans cycles k+1..k+HOLD_CYC.
- GAP spans the next GAP_CYC cycles.
- IDLE occupies at least one cycle.
- Maximum rate: one word per HOLD_CYC+GAP_CYC+1 cycles.
- With all req continuously high, grants rotate 0,1,..,NREQ-1,0.
- busy falls on the cycle state enters IDLE.

## Configuration
- MUX_ARB_ACK_EN defined: adds the ack input and err output.
  - HOLD exits early on ack. HOLD_CYC becomes a timeout.
  - If cnt reaches 0 without ack, err is set (sticky until rst) and the FSM proceeds to GAP normally.
  - ack on the same cycle as cnt==0 counts as ack; err is not set.
  - ack in IDLE or GAP is ignored.
- MUX_ARB_ACK_EN undefined: there is no ack/err logic. HOLD always lasts exactly HOLD_CYC cycles.

## Test plan
- Reset: hold rst 3 cycles with req=4'b1111 -> all outputs 0, no gnt. Release -> gnt=4'b0001 one cycle later, tx_data=req_data[0], tx_tag=1.
- Round-robin: all req high, HOLD_CYC=6, GAP_CYC=2 -> gnt pulses 0,1,2,3,0 spaced exactly 9 cycles apart; tx_data constant between pulses.
- Identical words: requester 2 alone, two consecutive requests with data 8'hA5 -> tx_data stays 8'hA5, tx_tag toggles 1->0 on the second grant.
- GAP_CYC=0, HOLD_CYC=1, req[1] always high -> gnt[1] pulses every 2 cycles; busy alternates 1,0.
- Reset mid-HOLD: assert rst on the 3rd HOLD cycle -> next edge state IDLE, tx_data=0, busy=0. After release, arbitration restarts at requester 0.
- MUX_ARB_ACK_EN:
  - ack on 2nd HOLD cycle -> GAP entered next edge, err=0.
  - No ack -> err=1 after HOLD_CYC cycles and remains 1 through subsequent successful transfers until rst.

Source files
------------

// File: rtl/mux_cdc_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mux_cdc_tx_arbiter_if
//  Purpose  : Requester / channel bundle for mux_cdc_tx_arbiter. The master
//             modport is the arbiter side; the slave modport is the
//             requester / channel side.
//  Options  : MUX_ARB_ACK_EN adds the ack input and the err output.
//  Revision : 1.0 - initial release
// ============================================================================
interface mux_cdc_tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic [DW-1:0]      tx_data;
  logic               tx_tag;
  logic [SW-1:0]      sel_id;
  logic               busy;
`ifdef MUX_ARB_ACK_EN
  logic               ack;
  logic               err;

  modport master (
    input  req, req_data, ack,
    output gnt, tx_data, tx_tag, sel_id, busy, err
  );
  modport slave (
    output req, req_data, ack,
    input  gnt, tx_data, tx_tag, sel_id, busy, err
  );
`else
  modport master (
    input  req, req_data,
    output gnt, tx_data, tx_tag, sel_id, busy
  );
  modport slave (
    output req, req_data,
    input  gnt, tx_data, tx_tag, sel_id, busy
  );
`endif
endinterface
`default_nettype wire

// File: rtl/mux_cdc_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux_cdc_tx_arbiter
//  Purpose  : Source-domain scheduler for a mux/N-flop CDC data channel.
//             Round-robins NREQ requesters, loads the winner's word, holds it
//             stable for HOLD_CYC cycles, then idles GAP_CYC cycles. tx_tag
//             toggles per word so repeated identical words remain visible.
//  Options  : MUX_ARB_ACK_EN - HOLD ends early on ack; HOLD_CYC becomes a
//             timeout that sets the sticky err flag.
//  Revision : 1.0 - initial release
// ============================================================================
module mux_cdc_tx_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int HOLD_CYC = 6,
  parameter int GAP_CYC  = 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  mux_cdc_tx_arbiter_if.master  bus
);
  localparam int SW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_MAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [SW-1:0] LAST_RST  = SW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [DW-1:0]     tx_data_q, tx_data_d;
  logic              tx_tag_q, tx_tag_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [SW-1:0]     last_q, last_d;
`ifdef MUX_ARB_ACK_EN
  logic              err_q, err_d;
`endif

  logic              win_found;
  logic              hi_found;
  logic [SW-1:0]     lo_idx, hi_idx, win_idx;
  logic [DW-1:0]     win_data;
  logic              hold_done;

  // Round-robin pick: lowest requester above last_q, else lowest overall (wrap).
  always_comb begin
    hi_found  = 1'b0;
    win_found = 1'b0;
    lo_idx    = '0;
    hi_idx    = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (bus.req[j]) begin
        win_found = 1'b1;
        lo_idx    = SW'(j);
        if (SW'(j) > last_q) begin
          hi_found = 1'b1;
          hi_idx   = SW'(j);
        end
      end
    end
    win_idx  = hi_found ? hi_idx : lo_idx;
    win_data = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (win_idx == SW'(j)) begin
        win_data = bus.req_data[j*DW +: DW];
      end
    end
  end

  // Next-state and output-register logic for the IDLE/HOLD/GAP sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d     = '0;
    tx_data_d = tx_data_q;
    tx_tag_d  = tx_tag_q;
    sel_d     = sel_q;
    last_d    = last_q;
    hold_done = 1'b0;
`ifdef MUX_ARB_ACK_EN
    err_d     = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          tx_data_d        = win_data;
          tx_tag_d         = ~tx_tag_q;
          gnt_d[win_idx]   = 1'b1;
          sel_d            = win_idx;
          last_d           = win_idx;
          cnt_d            = HOLD_LOAD;
          state_d          = S_HOLD;
        end
      end
      S_HOLD: begin
`ifdef MUX_ARB_ACK_EN
        // An ack on the final count still counts as a capture, not a timeout.
        if (bus.ack) begin
          hold_done = 1'b1;
        end else if (cnt_q == '0) begin
          hold_done = 1'b1;
          err_d     = 1'b1;
        end
`else
        hold_done = (cnt_q == '0);
`endif
        if (hold_done) begin
          if (GAP_CYC == 0) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = S_GAP;
            cnt_d   = GAP_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      gnt_q     <= '0;
      tx_data_q <= '0;
      tx_tag_q  <= 1'b0;
      sel_q     <= '0;
      last_q    <= LAST_RST;
`ifdef MUX_ARB_ACK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      tx_data_q <= tx_data_d;
      tx_tag_q  <= tx_tag_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
`ifdef MUX_ARB_ACK_EN
      err_q     <= err_d;
`endif
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.tx_data = tx_data_q;
  assign bus.tx_tag  = tx_tag_q;
  assign bus.sel_id  = sel_q;
  assign bus.busy    = (state_q != S_IDLE);
`ifdef MUX_ARB_ACK_EN
  assign bus.err     = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_cdc_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_cdc_tx_arbiter
//  Purpose  : Self-checking bench for mux_cdc_tx_arbiter. Instance A uses
//             HOLD_CYC=6/GAP_CYC=2, instance B uses HOLD_CYC=1/GAP_CYC=0.
//             A cycle-time model predicts every output; directed checks pin
//             hand-computed values.
//  Options  : MUX_ARB_ACK_EN - also exercises ack/err behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_cdc_tx_arbiter;
  localparam int NREQ   = 4;
  localparam int DW     = 8;
  localparam int HOLD_A = 6;
  localparam int GAP_A  = 2;
  localparam int HOLD_B = 1;
  localparam int GAP_B  = 0;
`ifdef MUX_ARB_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  logic b_done = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  mux_cdc_tx_arbiter_if #(.NREQ(NREQ), .DW(DW)) ifa ();
  mux_cdc_tx_arbiter_if #(.NREQ(NREQ), .DW(DW)) ifb ();

  mux_cdc_tx_arbiter #(.NREQ(NREQ), .DW(DW), .HOLD_CYC(HOLD_A), .GAP_CYC(GAP_A)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ifa.master)
  );

  mux_cdc_tx_arbiter #(.NREQ(NREQ), .DW(DW), .HOLD_CYC(HOLD_B), .GAP_CYC(GAP_B)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ifb.master)
  );

  // Model: each word occupies the channel for a fixed span of cycle numbers.
  typedef struct {
    bit              valid;
    int              idle_at;    // first cycle number in which a new grant may be taken
    int              hold_first;
    int              hold_last;
    int              last;
    logic [NREQ-1:0] gnt;
    logic [DW-1:0]   data;
    logic            tag;
    int              sel;
    logic            busy;
    logic            err;
  } model_t;

  model_t ma;
  model_t mb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Predict the outputs of cycle c+1 from the inputs seen during cycle c.
  task automatic model_step(inout model_t m, input int c, input logic r,
                            input logic [NREQ-1:0] rq, input logic [NREQ*DW-1:0] rd,
                            input logic ak, input int hold, input int gap);
    int w;
    w = -1;
    if (r) begin
      m.valid      = 1'b1;
      m.idle_at    = c + 1;
      m.hold_first = -1;
      m.hold_last  = -2;
      m.last       = NREQ - 1;
      m.gnt        = '0;
      m.data       = '0;
      m.tag        = 1'b0;
      m.sel        = 0;
      m.err        = 1'b0;
    end else if (m.valid) begin
      m.gnt = '0;
      if (c >= m.hold_first && c <= m.hold_last) begin
        if (ACK_EN && ak === 1'b1) begin
          m.hold_last = c;
          m.idle_at   = c + gap + 1;
        end else if (ACK_EN && c == m.hold_last) begin
          m.err = 1'b1;
        end
      end
      if (c >= m.idle_at && rq != '0) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (w < 0 && rq[(m.last + k) % NREQ]) w = (m.last + k) % NREQ;
        end
        m.gnt[w]     = 1'b1;
        m.data       = rd[w*DW +: DW];
        m.tag        = ~m.tag;
        m.sel        = w;
        m.last       = w;
        m.hold_first = c + 1;
        m.hold_last  = c + hold;
        m.idle_at    = c + hold + gap + 1;
      end
    end
    m.busy = ((c + 1) < m.idle_at);
  endtask

  // Compare both DUTs against the model each cycle, then advance the model.
  always @(negedge clk) begin
    logic ak_a;
    logic ak_b;
`ifdef MUX_ARB_ACK_EN
    ak_a = ifa.ack;
    ak_b = ifb.ack;
`else
    ak_a = 1'b0;
    ak_b = 1'b0;
`endif
    if (ma.valid) begin
      chk("A.gnt", ifa.gnt, ma.gnt);
      chk("A.tx_data", ifa.tx_data, ma.data);
      chk("A.tx_tag", ifa.tx_tag, ma.tag);
      chk("A.sel_id", ifa.sel_id, ma.sel);
      chk("A.busy", ifa.busy, ma.busy);
`ifdef MUX_ARB_ACK_EN
      chk("A.err", ifa.err, ma.err);
`endif
    end
    if (mb.valid) begin
      chk("B.gnt", ifb.gnt, mb.gnt);
      chk("B.tx_data", ifb.tx_data, mb.data);
      chk("B.tx_tag", ifb.tx_tag, mb.tag);
      chk("B.busy", ifb.busy, mb.busy);
`ifdef MUX_ARB_ACK_EN
      chk("B.err", ifb.err, mb.err);
`endif
    end
    model_step(ma, cyc, rst_a, ifa.req, ifa.req_data, ak_a, HOLD_A, GAP_A);
    model_step(mb, cyc, rst_b, ifb.req, ifb.req_data, ak_b, HOLD_B, GAP_B);
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout_chk(input string nm, input int t, input int limit);
    checks++;
    if (t >= limit) begin
      failures++;
      $display("FAIL %s: no event after %0d cycles, required within %0d", nm, t, limit);
    end
  endtask

  task automatic wait_gnt_a(input int limit, input string nm);
    int t;
    t = 0;
    while (t < limit && ifa.gnt == '0) begin tick(); t++; end
    timeout_chk(nm, t, limit);
  endtask

  task automatic wait_idle_a(input int limit, input string nm);
    int t;
    t = 0;
    while (t < limit && ifa.busy !== 1'b0) begin tick(); t++; end
    timeout_chk(nm, t, limit);
  endtask

  task automatic wait_gnt_b(input int limit, input string nm);
    int t;
    t = 0;
    while (t < limit && ifb.gnt == '0) begin tick(); t++; end
    timeout_chk(nm, t, limit);
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Instance A: reset, round-robin, identical words, abort, ack/err.
  initial begin : stim_a
    int n;
    int gidx[5];
    int gcyc[5];
    int exp_idx[5];
    exp_idx = '{0, 1, 2, 3, 0};
    rst_a        = 1'b1;
    ifa.req      = 4'b1111;
    ifa.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
`ifdef MUX_ARB_ACK_EN
    ifa.ack      = 1'b0;
`endif
    tick();
    chk("rst_gnt", ifa.gnt, 4'b0000);
    chk("rst_data", ifa.tx_data, 8'h00);
    chk("rst_tag", ifa.tx_tag, 1'b0);
    chk("rst_busy", ifa.busy, 1'b0);
    tick();
    tick();
    rst_a = 1'b0;
    tick();
    chk("first_gnt", ifa.gnt, 4'b0001);
    chk("first_data", ifa.tx_data, 8'h11);
    chk("first_tag", ifa.tx_tag, 1'b1);
    chk("first_busy", ifa.busy, 1'b1);

    n = 0;
    for (int t = 0; t < 60 && n < 5; t++) begin
      if (ifa.gnt != '0) begin
        gidx[n] = onehot_idx(ifa.gnt);
        gcyc[n] = cyc;
        n++;
      end
      if (n < 5) tick();
    end
    chk("rr_count", n, 5);
    for (int k = 0; k < 5; k++) chk("rr_idx", gidx[k], exp_idx[k]);
    for (int k = 1; k < 5; k++) chk("rr_spacing", gcyc[k] - gcyc[k-1], 9);
    ifa.req = 4'b0000;
    wait_idle_a(20, "rr_idle_wait");

    rst_a = 1'b1;
    tick();
    tick();
    rst_a        = 1'b0;
    ifa.req      = 4'b0100;
    ifa.req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
    wait_gnt_a(10, "same1_wait");
    chk("same1_gnt", ifa.gnt, 4'b0100);
    chk("same1_data", ifa.tx_data, 8'hA5);
    chk("same1_tag", ifa.tx_tag, 1'b1);
    tick();
    wait_gnt_a(20, "same2_wait");
    chk("same2_data", ifa.tx_data, 8'hA5);
    chk("same2_tag", ifa.tx_tag, 1'b0);
    chk("same2_sel", ifa.sel_id, 2);
    ifa.req = 4'b0000;

    wait_idle_a(20, "abort_idle_wait");
    ifa.req      = 4'b1111;
    ifa.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    wait_gnt_a(10, "abort_gnt_wait");
    chk("abort_gnt", ifa.gnt, 4'b1000);
    tick();
    tick();
    rst_a = 1'b1;
    tick();
    chk("abort_busy", ifa.busy, 1'b0);
    chk("abort_data", ifa.tx_data, 8'h00);
    chk("abort_gnt_clr", ifa.gnt, 4'b0000);
    rst_a = 1'b0;
    wait_gnt_a(10, "restart_wait");
    chk("restart_gnt", ifa.gnt, 4'b0001);
    chk("restart_sel", ifa.sel_id, 0);
    ifa.req = 4'b0000;
    wait_idle_a(20, "restart_idle_wait");

`ifdef MUX_ARB_ACK_EN
    rst_a = 1'b1;
    tick();
    rst_a   = 1'b0;
    ifa.req = 4'b0010;
    wait_gnt_a(10, "ack_gnt_wait");
    ifa.req = 4'b0000;
    tick();
    ifa.ack = 1'b1;
    tick();
    ifa.ack = 1'b0;
    chk("ack_gap_busy", ifa.busy, 1'b1);
    chk("ack_err", ifa.err, 1'b0);
    tick();
    tick();
    chk("ack_idle_busy", ifa.busy, 1'b0);

    ifa.req = 4'b0100;
    wait_gnt_a(10, "noack_gnt_wait");
    ifa.req = 4'b0000;
    repeat (5) tick();
    chk("noack_err_pre", ifa.err, 1'b0);
    tick();
    chk("noack_err", ifa.err, 1'b1);
    wait_idle_a(20, "sticky_idle_wait");
    ifa.req = 4'b1000;
    wait_gnt_a(10, "sticky_gnt_wait");
    ifa.req = 4'b0000;
    tick();
    ifa.ack = 1'b1;
    tick();
    ifa.ack = 1'b0;
    chk("sticky_err", ifa.err, 1'b1);
    repeat (3) tick();
    chk("sticky_err_idle", ifa.err, 1'b1);
`endif

    for (int t = 0; t < 100 && !b_done; t++) tick();
    checks++;
    if (!b_done) begin
      failures++;
      $display("FAIL b_done: instance B sequence did not complete");
    end
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Instance B: HOLD_CYC=1, GAP_CYC=0 gives a grant every second cycle.
  initial begin : stim_b
    rst_b        = 1'b1;
    ifb.req      = 4'b0010;
    ifb.req_data = {8'h00, 8'h00, 8'h5A, 8'h00};
`ifdef MUX_ARB_ACK_EN
    ifb.ack      = 1'b0;
`endif
    tick();
    tick();
    rst_b = 1'b0;
    wait_gnt_b(5, "b_gnt_wait");
    for (int i = 0; i < 8; i++) begin
      chk("b_gnt", ifb.gnt, (i % 2 == 0) ? 4'b0010 : 4'b0000);
      chk("b_busy", ifb.busy, (i % 2 == 0) ? 1'b1 : 1'b0);
      tick();
    end
    chk("b_data", ifb.tx_data, 8'h5A);
    b_done = 1'b1;
  end

  // Hard stop in case a wait is never satisfied.
  initial begin : watchdog
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
`default_nettype wire
